// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared state encoding and widths for the nibble-serial add/subtract controller.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result handshake bundle; master is the requester/consumer, slave is the adder.
interface nibble_serial_add_ctrl_if #(
  parameter int DATA_W = nibble_serial_add_ctrl_pkg::DATA_W_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              carry_out;
  logic              overflow;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_nibble_adder.sv
// Combinational 4-bit adder; zero latency, no flow control. c3 is the carry into bit 3,
// exposed so the caller can form signed overflow on the top nibble.
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] low;
  logic [1:0] high;

  assign low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
  assign c3   = low[3];
  assign high = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low[3]};
  assign sum  = {high[0], low[2:0]};
  assign cout = high[1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Serial add/sub through one 4-bit adder; out_valid DATA_W/4+1 edges after accept.
// in_ready only while idle; result/flags held in DONE until out_ready.
module nibble_serial_add_ctrl #(
  parameter int DATA_W   = nibble_serial_add_ctrl_pkg::DATA_W_DEFAULT,
  parameter int NIBBLE_W = nibble_serial_add_ctrl_pkg::NIBBLE_W
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_add_ctrl_if.slave bus
);

  import nibble_serial_add_ctrl_pkg::*;

  localparam int NUM_NIB = DATA_W / NIBBLE_W;
  localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx_q;
  logic              fin_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_out_q;
  logic              overflow_q;

  logic              accept;
  logic              in_ready_c;
  logic              out_valid_c;
  logic [IDX_W+1:0]  bit_base;
  logic [3:0]        nib_sum;
  logic              nib_cout;
  logic              nib_c3;

  assign bit_base = {idx_q, 2'b00};
  assign accept   = bus.in_valid && in_ready_c;

  nibble_adder u_nibble_adder (
    .a    (a_q[bit_base +: NIBBLE_W]),
    .b    (b_q[bit_base +: NIBBLE_W]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // fin_q adds one settle cycle after the last nibble so DONE is entered with flags already latched.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fin_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Subtraction is a + ~b + 1: B is stored inverted and the +1 rides in as the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      fin_q       <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.op_a;
      b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
      carry_q <= bus.sub;
      idx_q   <= '0;
      fin_q   <= 1'b0;
    end else if (state_q == RUN && !fin_q) begin
      result_q[bit_base +: NIBBLE_W] <= nib_sum;
      carry_q <= nib_cout;
      if (idx_q == LAST_IDX) begin
        carry_out_q <= nib_cout;
        overflow_q  <= nib_c3 ^ nib_cout;
        fin_q       <= 1'b1;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: requests scored against an arithmetic model via a result queue.
module tb_nibble_serial_add_ctrl;

  localparam int DATA_W  = 16;
  localparam int NUM_NIB = DATA_W / 4;
  localparam int LAT     = NUM_NIB + 1;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              co;
    logic              ov;
    int                acc;
    string             tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_mode = 2;
  exp_t exp_q[$];

  nibble_serial_add_ctrl_if #(.DATA_W(DATA_W)) bus ();

  nibble_serial_add_ctrl #(.DATA_W(DATA_W), .NIBBLE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic s, input string tag);
    exp_t   e;
    longint ua = a;
    longint ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint r;
    longint smax = (longint'(1) <<< (DATA_W - 1)) - 1;
    longint smin = -(longint'(1) <<< (DATA_W - 1));
    if (s) begin
      e.res = DATA_W'(ua - ub);
      e.co  = (ua >= ub);
      r     = sa - sb;
    end else begin
      e.res = DATA_W'(ua + ub);
      e.co  = ((ua + ub) >> DATA_W) != 0;
      r     = sa + sb;
    end
    e.ov  = (r > smax) || (r < smin);
    e.acc = 0;
    e.tag = tag;
    return e;
  endfunction

  // Holds in_valid until accepted, records the accept edge, then scrambles operands.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic s, input string tag);
    bit   done = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        e     = model(a, b, s, tag);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        done  = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.op_a     = DATA_W'($urandom);
    bus.op_b     = DATA_W'($urandom);
    bus.sub      = 1'($urandom_range(0, 1));
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s.accept_timeout: in_ready never high, expected accept within 200 cycles", tag);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  bus.in_ready,  1);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".result"},    bus.result,    0);
    chk({tag, ".carry_out"}, bus.carry_out, 0);
    chk({tag, ".overflow"},  bus.overflow,  0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: every DONE cycle is compared against the queue head; handshake pops it.
  initial begin
    bit   seen = 0;
    bit   popped = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen   = 0;
        popped = 0;
      end else begin
        if (popped) begin
          chk("post_handshake.in_ready",  bus.in_ready,  1);
          chk("post_handshake.out_valid", bus.out_valid, 0);
          popped = 0;
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got result 0x%0h, expected no result", bus.result);
          end else begin
            e = exp_q[0];
            if (!seen) begin
              chk({e.tag, ".latency"}, cyc - e.acc, LAT);
              seen = 1;
            end
            chk({e.tag, ".result"},    bus.result,    e.res);
            chk({e.tag, ".carry_out"}, bus.carry_out, e.co);
            chk({e.tag, ".overflow"},  bus.overflow,  e.ov);
            chk({e.tag, ".in_ready"},  bus.in_ready,  0);
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              seen   = 0;
              popped = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.sub      = 1'b0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    send(16'h1234, 16'h4321, 1'b0, "add_1234_4321");
    send(16'hFFFF, 16'h0001, 1'b0, "add_carry");
    send(16'h7FFF, 16'h0001, 1'b0, "add_overflow");
    send(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    send(16'h8000, 16'h0001, 1'b1, "sub_overflow");
    drain(100);

    // Stall the consumer in DONE for several cycles.
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(16'hA5A5, 16'h1111, 1'b0, "hold");
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold.reached_done", bus.out_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 2;
    drain(20);

    // Abort in the second RUN cycle, then restart.
    send(16'h1111, 16'h2222, 1'b0, "aborted");
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_outputs("mid_run_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h0001, 16'h0001, 1'b0, "after_reset");
    drain(50);

    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      a = DATA_W'($urandom);
      b = DATA_W'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'h8000;
        1: b = 16'h8000;
        2: a = 16'h7FFF;
        3: b = a;
        default: ;
      endcase
      send(a, b, 1'($urandom_range(0, 1)), "random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 2;
    drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
